// File: rtl/cpu_pkg.sv
// cpu_pkg: shared 6502 core types, status-register bit indices and branch codes
package cpu_pkg;
  typedef enum logic [2:0] {
    FLAG_NONE, FLAG_CLC, FLAG_SEC, FLAG_CLI, FLAG_SEI, FLAG_CLV, FLAG_CLD, FLAG_SED
  } flag_op_t;
  localparam logic [2:0] BR_BPL = 3'b000;
  localparam logic [2:0] BR_BMI = 3'b001;
  localparam logic [2:0] BR_BVC = 3'b010;
  localparam logic [2:0] BR_BVS = 3'b011;
  localparam logic [2:0] BR_BCC = 3'b100;
  localparam logic [2:0] BR_BCS = 3'b101;
  localparam logic [2:0] BR_BNE = 3'b110;
  localparam logic [2:0] BR_BEQ = 3'b111;
  localparam int P_N = 7;
  localparam int P_V = 6;
  localparam int P_D = 3;
  localparam int P_I = 2;
  localparam int P_Z = 1;
  localparam int P_C = 0;
  localparam logic [7:0] RESET_P = 8'h24;
endpackage

// File: rtl/int_ctrl.sv
// int_ctrl: NMI edge latch, IRQ gating and instruction-boundary interrupt request
module int_ctrl (
  input  logic clk,
  input  logic reset_n,
  input  logic nmi_n,
  input  logic irq_n,
  input  logic p_i,
  input  logic instr_done,
  input  logic int_ack,
  output logic int_req,
  output logic int_nmi
);
  logic nmi_d, nmi_pend;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nmi_d    <= 1'b0;
      nmi_pend <= 1'b0;
      int_req  <= 1'b0;
      int_nmi  <= 1'b0;
    end else begin
      nmi_d    <= nmi_n;
      // a fresh edge wins over an ack that would clear the previous one
      nmi_pend <= (nmi_d & ~nmi_n) | (nmi_pend & ~(int_ack & int_nmi));
      int_req  <= int_ack ? 1'b0 : instr_done ? nmi_pend | (~irq_n & ~p_i) : int_req;
      int_nmi  <= int_ack ? 1'b0 : instr_done ? nmi_pend : int_nmi;
    end
  end
endmodule

// File: rtl/status_reg.sv
// status_reg: 6502 processor status register, branch evaluation and interrupt polling
module status_reg
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  input  logic       alu_sign,
  input  logic       flag_we,
  input  logic [3:0] flag_mask,
  input  flag_op_t   flag_op,
  input  logic       p_load,
  input  logic [7:0] p_din,
  input  logic       bit_load,
  input  logic       push_brk,
  input  logic [2:0] branch_cond,
  input  logic       instr_done,
  input  logic       int_ack,
  input  logic       nmi_n,
  input  logic       irq_n,
  output logic [7:0] p,
  output logic [7:0] p_out,
  output logic       carry_flag,
  output logic       branch_taken,
  output logic       int_req,
  output logic       int_nmi
);
  logic [7:0] p_q, p_nxt;
  always_comb begin
    p_nxt      = p_q;
    p_nxt[P_C] = flag_op == FLAG_CLC ? 1'b0 : flag_op == FLAG_SEC ? 1'b1 :
                 flag_we && flag_mask[0] ? alu_carry : p_q[P_C];
    p_nxt[P_Z] = bit_load || (flag_we && flag_mask[1]) ? alu_zero : p_q[P_Z];
    p_nxt[P_I] = int_ack || flag_op == FLAG_SEI ? 1'b1 : flag_op == FLAG_CLI ? 1'b0 : p_q[P_I];
    p_nxt[P_D] = flag_op == FLAG_SED ? 1'b1 : flag_op == FLAG_CLD ? 1'b0 : p_q[P_D];
    p_nxt[P_V] = flag_op == FLAG_CLV ? 1'b0 : bit_load ? p_din[6] :
                 flag_we && flag_mask[2] ? alu_overflow : p_q[P_V];
    p_nxt[P_N] = bit_load ? p_din[7] : flag_we && flag_mask[3] ? alu_sign : p_q[P_N];
    // bit5 reads 1 and B is never stored
    if (p_load) p_nxt = (p_din | 8'h20) & 8'hEF;
  end
  always_ff @(posedge clk) p_q <= !reset_n ? RESET_P : p_nxt;
  always_comb begin
    p            = p_q;
    p_out        = {p_q[7:6], 1'b1, push_brk, p_q[3:0]};
    carry_flag   = p_q[P_C];
    branch_taken = branch_cond == BR_BPL ? ~p_q[P_N] :
                   branch_cond == BR_BMI ?  p_q[P_N] :
                   branch_cond == BR_BVC ? ~p_q[P_V] :
                   branch_cond == BR_BVS ?  p_q[P_V] :
                   branch_cond == BR_BCC ? ~p_q[P_C] :
                   branch_cond == BR_BCS ?  p_q[P_C] :
                   branch_cond == BR_BNE ? ~p_q[P_Z] : p_q[P_Z];
  end
  int_ctrl u_int_ctrl (
    .clk        (clk),
    .reset_n    (reset_n),
    .nmi_n      (nmi_n),
    .irq_n      (irq_n),
    .p_i        (p_q[P_I]),
    .instr_done (instr_done),
    .int_ack    (int_ack),
    .int_req    (int_req),
    .int_nmi    (int_nmi)
  );
endmodule

// File: tb/tb_status_reg.sv
// tb_status_reg: directed vectors against hand-computed status register values
module tb_status_reg;
  import cpu_pkg::*;
  logic clk = 1'b0, reset_n;
  logic alu_carry, alu_overflow, alu_zero, alu_sign, flag_we;
  logic [3:0] flag_mask;
  flag_op_t flag_op;
  logic p_load, bit_load, push_brk, instr_done, int_ack, nmi_n, irq_n;
  logic [7:0] p_din, p, p_out;
  logic [2:0] branch_cond;
  logic carry_flag, branch_taken, int_req, int_nmi;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  status_reg dut (
    .clk(clk), .reset_n(reset_n), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_sign(alu_sign), .flag_we(flag_we), .flag_mask(flag_mask),
    .flag_op(flag_op), .p_load(p_load), .p_din(p_din), .bit_load(bit_load),
    .push_brk(push_brk), .branch_cond(branch_cond), .instr_done(instr_done),
    .int_ack(int_ack), .nmi_n(nmi_n), .irq_n(irq_n), .p(p), .p_out(p_out),
    .carry_flag(carry_flag), .branch_taken(branch_taken), .int_req(int_req), .int_nmi(int_nmi)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    reset_n = 1'b1; {alu_carry, alu_overflow, alu_zero, alu_sign, flag_we} = '0;
    flag_mask = '0; flag_op = FLAG_NONE; p_load = 1'b0; p_din = '0; bit_load = 1'b0;
    push_brk = 1'b0; branch_cond = '0; instr_done = 1'b0; int_ack = 1'b0;
    nmi_n = 1'b1; irq_n = 1'b1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      {alu_carry, alu_overflow, alu_zero, alu_sign, flag_we} = 5'($urandom);
      flag_mask = 4'($urandom); flag_op = flag_op_t'(3'($urandom)); p_load = 1'($urandom);
      p_din = 8'($urandom); bit_load = 1'($urandom); instr_done = 1'($urandom);
      int_ack = 1'($urandom); irq_n = 1'($urandom); nmi_n = 1'b0;
      step();
    end
    check("rst_p", p, 8'h24);
    check("rst_req", {7'd0, int_req}, 8'd0);
    check("rst_c", {7'd0, carry_flag}, 8'd0);
    idle(); nmi_n = 1'b0; instr_done = 1'b1; step();
    check("rst_nmi_low", {7'd0, int_req}, 8'd0);
    idle(); flag_op = FLAG_SED; step();
    check("sed", p, 8'h2C);
    idle(); flag_op = FLAG_CLD; flag_we = 1'b1; flag_mask = 4'hF;
    alu_carry = 1'b1; alu_overflow = 1'b1; alu_sign = 1'b1; step();
    check("alu_all", p, 8'hE5);
    idle(); flag_we = 1'b1; flag_mask = 4'h1; step();
    check("alu_c", p, 8'hE4);
    check("c_out0", {7'd0, carry_flag}, 8'd0);
    idle(); flag_op = FLAG_SEC; flag_we = 1'b1; flag_mask = 4'h1; step();
    check("sec_wins", p, 8'hE5);
    check("c_out1", {7'd0, carry_flag}, 8'd1);
    branch_cond = BR_BCS; #1 check("bcs", {7'd0, branch_taken}, 8'd1);
    branch_cond = BR_BCC; #1 check("bcc", {7'd0, branch_taken}, 8'd0);
    branch_cond = BR_BMI; #1 check("bmi", {7'd0, branch_taken}, 8'd1);
    branch_cond = BR_BNE; #1 check("bne", {7'd0, branch_taken}, 8'd1);
    branch_cond = BR_BVC; #1 check("bvc", {7'd0, branch_taken}, 8'd0);
    idle(); bit_load = 1'b1; p_din = 8'hC0; flag_op = FLAG_CLV; flag_we = 1'b1;
    flag_mask = 4'hF; alu_carry = 1'b1; alu_zero = 1'b0; step();
    check("bit_clv", p, 8'hA5);
    branch_cond = BR_BEQ; #1 check("beq", {7'd0, branch_taken}, 8'd0);
    idle(); p_load = 1'b1; p_din = 8'hFF; flag_op = FLAG_CLC; flag_we = 1'b1; step();
    check("plp", p, 8'hEF);
    push_brk = 1'b1; #1 check("php_b1", p_out, 8'hFF);
    push_brk = 1'b0; #1 check("php_b0", p_out, 8'hEF);
    idle(); irq_n = 1'b0; instr_done = 1'b1; step();
    check("irq_masked", {7'd0, int_req}, 8'd0);
    flag_op = FLAG_CLI; step();
    check("cli_late", {7'd0, int_req}, 8'd0);
    check("cli_p", p, 8'hEB);
    flag_op = FLAG_NONE; step();
    check("irq_req", {6'd0, int_req, int_nmi}, 8'b10);
    idle(); int_ack = 1'b1; step();
    check("irq_ack", {6'd0, int_req, int_nmi}, 8'b00);
    check("ack_sets_i", p, 8'hEF);
    idle(); step();
    nmi_n = 1'b0; step();
    check("nmi_latency", {7'd0, int_req}, 8'd0);
    instr_done = 1'b1; step();
    check("nmi_req", {6'd0, int_req, int_nmi}, 8'b11);
    instr_done = 1'b0; int_ack = 1'b1; step();
    check("nmi_ack", {6'd0, int_req, int_nmi}, 8'b00);
    int_ack = 1'b0; instr_done = 1'b1; step();
    check("nmi_held", {7'd0, int_req}, 8'd0);
    idle(); step();
    nmi_n = 1'b0; step();
    instr_done = 1'b1; step();
    check("nmi_req2", {6'd0, int_req, int_nmi}, 8'b11);
    idle(); step();
    nmi_n = 1'b0; int_ack = 1'b1; step();
    check("edge_ack", {7'd0, int_req}, 8'd0);
    int_ack = 1'b0; instr_done = 1'b1; step();
    check("edge_kept", {6'd0, int_req, int_nmi}, 8'b11);
    idle(); reset_n = 1'b0; flag_op = FLAG_SEC; step();
    check("mid_rst_p", p, 8'h24);
    check("mid_rst_req", {6'd0, int_req, int_nmi}, 8'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/status_reg.md
# status_reg

Processor status (P) register for the 6502 core. It sits directly downstream of `alu`: it captures the ALU's carry/overflow/zero/sign outputs under per-instruction masks and feeds the stored carry back as `alu` carry_in. It also handles explicit flag instructions, PLP/RTI loads, PHP/BRK push formatting and branch-condition evaluation. It detects NMI edges and gates IRQ, raising a registered interrupt request to the sequencer at instruction boundaries.

## Interface
- RESET_P, 8'h24, P value after reset (I=1, bit5=1)
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- alu_carry, alu_overflow, alu_zero, alu_sign  in  1 each  flag outputs of `alu`
- flag_we  in  1  apply masked ALU flags this cycle
- flag_mask  in  4  bit3 N, bit2 V, bit1 Z, bit0 C
- flag_op  in  3  explicit flag op (flag_op_t)
- p_load  in  1  load P from p_din (PLP/RTI)
- p_din  in  8  data bus byte
- bit_load  in  1  BIT: N<=p_din[7], V<=p_din[6], Z<=alu_zero
- push_brk  in  1  B bit value for p_out
- branch_cond  in  3  branch code (opcode[7:5])
- instr_done  in  1  last cycle of current instruction
- int_ack  in  1  sequencer begins interrupt sequence
- nmi_n, irq_n  in  1  interrupt pins, already synchronised upstream
- p  out  8  current P
- p_out  out  8  push value
- carry_flag  out  1  P.C, to `alu` carry_in
- branch_taken  out  1  condition met for branch_cond
- int_req  out  1  interrupt to be serviced
- int_nmi  out  1  pending request is NMI

## Operation
- P bit layout: N7 V6 1(5) B4 D3 I2 Z1 C0. Bit5 always reads 1. Bit4 is never stored and always reads 0 in `p`.
- Priority per cycle:
  - p_load overrides everything. P <= p_din with bit5 forced to 1 and bit4 forced to 0.
  - Otherwise the following all apply together: flag_we updates the masked bits from the ALU, bit_load updates N/V/Z, flag_op updates its bit, int_ack sets I.
  - On a same-bit conflict: flag_op > bit_load > flag_we.
- flag_op: 0 NONE, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED. D is stored but has no arithmetic effect.
- p_out = {P[7:6], 1, push_brk, P[3:0]}.
- branch_cond (true when):
  - 000 BPL: N=0
  - 001 BMI: N=1
  - 010 BVC: V=0
  - 011 BVS: V=1
  - 100 BCC: C=0
  - 101 BCS: C=1
  - 110 BNE: Z=0
  - 111 BEQ: Z=1
- NMI edge detection:
  - nmi_d register. A falling edge (nmi_d=1, nmi_n=0) sets nmi_pend.
  - int_ack while int_nmi=1 clears nmi_pend.
  - If a new edge and a clearing ack occur in the same cycle, nmi_pend stays set.
  - Holding nmi_n low never retriggers.
- IRQ is level-sensitive and not latched.
- Polling: on a cycle with instr_done=1, int_req <= nmi_pend | (~irq_n & ~P.I), and int_nmi <= nmi_pend.
  - The poll uses P.I as registered before that cycle's update. As a result, CLI/SEI/PLP take effect one instruction late.
- int_ack clears int_req and int_nmi, and takes precedence over a same-cycle poll.

## Timing
- All state updates on rising clk.
- p, p_out, carry_flag and branch_taken are combinational from registered P. They reflect P before any same-cycle update.
- ALU flags presented with flag_we in cycle N are visible on p in cycle N+1.
- Reset (reset_n=0 at the clk edge, any cycle, including mid-instruction or mid-interrupt):
  - P=RESET_P, nmi_pend=0, int_req=0, int_nmi=0.
  - nmi_d=0, so a pin held low through reset is not an edge.
  - All other inputs are ignored while in reset.
- Latency from nmi_n falling to int_req: edge registered at the next clk, then int_req set at the next instr_done clk (min 2 cycles).

## Structure
- Shared package `cpu_pkg`: flag_op_t, branch code constants, P bit index constants (P_N..P_C), RESET_P value. It sits alongside the existing alu mode enum.
- One sub-module: `int_ctrl` (nmi_d, nmi_pend, int_req, int_nmi, poll/ack logic), taking P.I as an input.

## Test plan
- Reset: reset_n=0 for 2 cycles with random inputs and nmi_n=0 -> p=8'h24, int_req=0, carry_flag=0; release with nmi_n=0 -> no int_req at instr_done.
- ALU capture:
  - flag_we with mask 4'hF, carry=1, overflow=1, zero=0, sign=1 -> p=8'hE5 next cycle.
  - Then mask 4'h1 with carry=0 -> p=8'hE4.
- Conflicts and branches:
  - SEC with flag_we, mask 4'h1, carry=0 -> C=1.
  - branch_cond 101 -> branch_taken=1; 100 -> 0.
- PLP and push:
  - p_load with p_din=8'hFF -> p=8'hEF.
  - push_brk=1 -> p_out=8'hFF; push_brk=0 -> 8'hEF.
- IRQ gating:
  - I=1 and irq_n=0: instr_done -> int_req=0.
  - CLI on an instr_done cycle -> int_req still 0.
  - Next instr_done -> int_req=1, int_nmi=0.
  - int_ack -> int_req=0, P.I=1.
- NMI:
  - With I=1, nmi_n 1->0, then instr_done -> int_req=1, int_nmi=1.
  - int_ack -> cleared; nmi_n held low, further instr_done -> int_req=0.
  - Edge coincident with ack -> int_req=1 at next instr_done.
